inv_subbytes_seq: RTL



---
 rtl/inv_subbytes_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/inv_subbytes_seq.sv
// Time-multiplexed AES InvSubBytes: LANES external inv_sbox lookups per cycle over a 16-byte state.
// Define INV_SUBBYTES_SEQ_PIPE_EN to register sb_dout before write-back (adds one drain cycle).
module inv_subbytes_seq #(
  parameter int LANES = 1,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [127:0]         in_state,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [127:0]         out_state,
  output logic [4*LANES-1:0]   sb_x,
  output logic [4*LANES-1:0]   sb_y,
  input  logic [8*LANES-1:0]   sb_dout,
  output logic                 busy
);
  localparam int GROUPS = 16 / LANES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  // Index 0 is the MSB byte, so the packed vector maps straight onto in_state/out_state.
  logic [0:15][7:0]      work;
  logic [CNT_W-1:0]      cnt;
  logic [0:LANES-1][7:0] dout_l;
  logic [0:LANES-1][3:0] x_l, y_l;
  logic                  look;
  logic                  last;

  assign dout_l = sb_dout;
  assign last   = (cnt == LAST);

  function automatic logic [3:0] bidx(input logic [CNT_W-1:0] c, input int k);
    int b;
    b = int'(c) * LANES + k;
    return b[3:0];
  endfunction

`ifdef INV_SUBBYTES_SEQ_PIPE_EN
  logic                  drain;
  logic                  pipe_vld;
  logic [CNT_W-1:0]      pipe_cnt;
  logic [0:LANES-1][7:0] pipe_data;
  assign look = (state == RUN) && !drain;
`else
  assign look = (state == RUN);
`endif

  always_comb begin
    x_l = '0;
    y_l = '0;
    for (int k = 0; k < LANES; k++) begin
      if (look) begin
        x_l[k] = work[bidx(cnt, k)][7:4];
        y_l[k] = work[bidx(cnt, k)][3:0];
      end
    end
  end

  assign sb_x = x_l;
  assign sb_y = y_l;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = RUN;
`ifdef INV_SUBBYTES_SEQ_PIPE_EN
      RUN:  if (drain) state_nx = DONE;
`else
      RUN:  if (last) state_nx = DONE;
`endif
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign out_state = out_valid ? work : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
`ifdef INV_SUBBYTES_SEQ_PIPE_EN
      drain     <= 1'b0;
      pipe_vld  <= 1'b0;
      pipe_cnt  <= '0;
      pipe_data <= '0;
`endif
    end else begin
      state <= state_nx;
`ifdef INV_SUBBYTES_SEQ_PIPE_EN
      pipe_vld <= 1'b0;
      // Write-back of the previous cycle's lookups; the drain cycle lands the final group.
      if (pipe_vld)
        for (int k = 0; k < LANES; k++) work[bidx(pipe_cnt, k)] <= pipe_data[k];
`endif
      case (state)
        IDLE: if (in_valid) begin
          work <= in_state;
          cnt  <= '0;
`ifdef INV_SUBBYTES_SEQ_PIPE_EN
          drain <= 1'b0;
`endif
        end
        RUN: if (look) begin
          cnt <= last ? '0 : cnt + 1'b1;
`ifdef INV_SUBBYTES_SEQ_PIPE_EN
          pipe_vld  <= 1'b1;
          pipe_cnt  <= cnt;
          pipe_data <= dout_l;
          if (last) drain <= 1'b1;
`else
          for (int k = 0; k < LANES; k++) work[bidx(cnt, k)] <= dout_l[k];
`endif
        end
        default: ;
      endcase
    end
  end
endmodule
